// File: rtl/swin_pkg.sv
// rtl/swin_pkg.sv - shared types and helpers for the sliding window generator
// Holds the FSM state encoding and the window slice-index helper.
package swin_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } swin_state_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Slice k of the flattened window for row i, column j (slice 0 is top-left).
  function automatic int idx(input int i, input int j, input int win);
    return i * win + j;
  endfunction

endpackage

// File: rtl/swin_line_buf.sv
// rtl/swin_line_buf.sv - WIN-1 row line buffers with column read and shift-write
// Ports:
//   clk      rising-edge clock
//   wr_en    shift-write enable (one accepted pixel)
//   col      column being read and written
//   pix_in   newest pixel, written into row buffer 0
//   col_out  slice k = buffer k at column col (buffer 0 = most recent row)
module swin_line_buf
  import swin_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int WIN   = 3
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(IMG_W)-1:0]   col,
  input  logic [PIX_W-1:0]           pix_in,
  output logic [(WIN-1)*PIX_W-1:0]   col_out
);

  // Contents are intentionally not reset: every row is written before it
  // can contribute to a valid window.
  logic [PIX_W-1:0] mem [WIN-1][IMG_W];

  always_comb begin
    col_out = '0;
    for (int k = 0; k < WIN - 1; k++) begin
      col_out[k*PIX_W +: PIX_W] = mem[k][col];
    end
  end

  // Each column acts as a vertical shift register: older rows move down.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[0][col] <= pix_in;
      for (int k = 1; k < WIN - 1; k++) begin
        mem[k][col] <= mem[k-1][col];
      end
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// rtl/sliding_window_gen.sv - streaming WIN x WIN window generator (top level)
// Ports:
//   CLK, Reset_n          clock, asynchronous active-low reset
//   Start                 one-cycle frame start, honoured in IDLE only
//   In_Valid/In_Ready     raster-order pixel input handshake, In_Pix data
//   Win_Valid/Out_Ready   window output handshake
//   Win                   window, slice i*WIN+j = pixel (r-WIN+1+i, c-WIN+1+j)
//   Win_Row, Win_Col      centre coordinates of Win
//   Busy                  high in RUN and DRAIN
//   Complete              one-cycle pulse in DONE
//   Stall_Cnt             (only with SWIN_STATS_EN) saturating backpressure cycle count
module sliding_window_gen
  import swin_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int WIN   = 3
) (
  input  logic                       CLK,
  input  logic                       Reset_n,
  input  logic                       Start,
  input  logic                       In_Valid,
  input  logic [PIX_W-1:0]           In_Pix,
  output logic                       In_Ready,
  output logic                       Win_Valid,
  input  logic                       Out_Ready,
  output logic [WIN*WIN*PIX_W-1:0]   Win,
  output logic [$clog2(IMG_H)-1:0]   Win_Row,
  output logic [$clog2(IMG_W)-1:0]   Win_Col,
  output logic                       Busy,
  output logic                       Complete
`ifdef SWIN_STATS_EN
  ,
  output logic [15:0]                Stall_Cnt
`endif
);

  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int HALF = (WIN - 1) / 2;

  swin_state_t state_q, state_d;

  logic [RW-1:0]              r_q;
  logic [CW-1:0]              c_q;
  logic [WIN*WIN*PIX_W-1:0]   win_q, win_d;
  logic [(WIN-1)*PIX_W-1:0]   lb_col;
  logic                       win_valid_q;
  logic                       run;
  logic                       accept;
  logic                       handshake;
  logic                       last_pix;
  logic                       start_acc;
  logic                       new_valid;

  assign In_Ready  = run && !(win_valid_q && !Out_Ready);
  assign accept    = In_Valid && In_Ready;
  assign handshake = win_valid_q && Out_Ready;
  assign start_acc = (state_q == S_IDLE) && Start;
  assign last_pix  = (r_q == RW'(IMG_H - 1)) && (c_q == CW'(IMG_W - 1));
  // Only windows lying completely inside the image are presented.
  assign new_valid = (r_q >= RW'(WIN - 1)) && (c_q >= CW'(WIN - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_RUN;
      S_RUN:   if (accept && last_pix) state_d = S_DRAIN;
      // The last pixel always yields a valid window, so DRAIN waits for it.
      S_DRAIN: if (handshake) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run      = (state_q == S_RUN);
    Busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    Complete = (state_q == S_DONE);
  end

  // ----------------------------------------------------------- counters
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q <= '0;
      c_q <= '0;
    end else if (start_acc) begin
      r_q <= '0;
      c_q <= '0;
    end else if (accept) begin
      if (c_q == CW'(IMG_W - 1)) begin
        c_q <= '0;
        r_q <= r_q + 1'b1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------- line buffer
  swin_line_buf #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .WIN   (WIN)
  ) u_line_buf (
    .clk     (CLK),
    .wr_en   (accept),
    .col     (c_q),
    .pix_in  (In_Pix),
    .col_out (lb_col)
  );

  // Window shifts one column left; the new right column comes from the line
  // buffers (oldest row at the top) with the incoming pixel at the bottom.
  // Columns left over from the previous row stay stale until refilled; they
  // only appear in windows with c < WIN-1, which are never valid.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN - 1; j++) begin
        win_d[idx(i, j, WIN)*PIX_W +: PIX_W] = win_q[idx(i, j + 1, WIN)*PIX_W +: PIX_W];
      end
    end
    for (int i = 0; i < WIN - 1; i++) begin
      win_d[idx(i, WIN - 1, WIN)*PIX_W +: PIX_W] = lb_col[(WIN-2-i)*PIX_W +: PIX_W];
    end
    win_d[idx(WIN - 1, WIN - 1, WIN)*PIX_W +: PIX_W] = In_Pix;
  end

  // ------------------------------------------------------ output registers
  // An accept may coincide with a handshake: the old window is consumed and
  // the new one loaded in the same cycle, which gives full throughput.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      win_q       <= '0;
      win_valid_q <= 1'b0;
      Win_Row     <= '0;
      Win_Col     <= '0;
    end else if (accept) begin
      win_q       <= win_d;
      win_valid_q <= new_valid;
      if (new_valid) begin
        Win_Row <= r_q - RW'(HALF);
        Win_Col <= c_q - CW'(HALF);
      end
    end else if (handshake) begin
      win_valid_q <= 1'b0;
    end
  end

  assign Win       = win_q;
  assign Win_Valid = win_valid_q;

`ifdef SWIN_STATS_EN
  // Backpressure statistics: held in IDLE, cleared by an accepted Start.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_Cnt <= '0;
    end else if (state_q == S_IDLE) begin
      if (Start) Stall_Cnt <= '0;
    end else if (win_valid_q && !Out_Ready && (Stall_Cnt != STALL_MAX)) begin
      Stall_Cnt <= Stall_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sliding_window_gen.sv
// tb/tb_sliding_window_gen.sv - scoreboard bench for sliding_window_gen (WIN=3 8x4 and WIN=5 8x6)
module tb_sliding_window_gen;

  typedef struct {
    logic [199:0] win;
    int           row;
    int           col;
  } exp_t;

  // Hand-derived reference windows for WIN=3, IMG_W=8 (slice 8 is the MSB byte).
  localparam logic [71:0] FIRST3 = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] THIRD3 = {8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10, 8'd4, 8'd3, 8'd2};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------------------------------------------------- WIN=3 DUT
  logic        Reset_n;
  logic        start3, in_valid3, out_ready3;
  logic [7:0]  in_pix3;
  logic        in_ready3, win_valid3, busy3, complete3;
  logic [71:0] win3;
  logic [1:0]  row3;
  logic [2:0]  col3;
`ifdef SWIN_STATS_EN
  logic [15:0] stall_cnt3, stall_cnt5;
`endif

  sliding_window_gen #(.PIX_W(8), .IMG_W(8), .IMG_H(4), .WIN(3)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(start3), .In_Valid(in_valid3), .In_Pix(in_pix3),
    .In_Ready(in_ready3), .Win_Valid(win_valid3), .Out_Ready(out_ready3), .Win(win3),
    .Win_Row(row3), .Win_Col(col3), .Busy(busy3), .Complete(complete3)
`ifdef SWIN_STATS_EN
    , .Stall_Cnt(stall_cnt3)
`endif
  );

  // ---------------------------------------------------------- WIN=5 DUT
  logic         rst5_n;
  logic         start5, in_valid5, out_ready5;
  logic [7:0]   in_pix5;
  logic         in_ready5, win_valid5, busy5, complete5;
  logic [199:0] win5;
  logic [2:0]   row5, col5;

  sliding_window_gen #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .WIN(5)) dut5 (
    .CLK(CLK), .Reset_n(rst5_n), .Start(start5), .In_Valid(in_valid5), .In_Pix(in_pix5),
    .In_Ready(in_ready5), .Win_Valid(win_valid5), .Out_Ready(out_ready5), .Win(win5),
    .Win_Row(row5), .Win_Col(col5), .Busy(busy5), .Complete(complete5)
`ifdef SWIN_STATS_EN
    , .Stall_Cnt(stall_cnt5)
`endif
  );

  exp_t sb3[$];
  exp_t sb5[$];

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window with bottom-right pixel (r,c), pixel value = row*iw+col.
  function automatic logic [199:0] mk_win(input int r, input int c, input int win, input int iw);
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < win; i++)
      for (int j = 0; j < win; j++)
        v[(i*win+j)*8 +: 8] = 8'((r - win + 1 + i) * iw + (c - win + 1 + j));
    return v;
  endfunction

  // ---------------------------------------------- WIN=3 Out_Ready control
  int hs3 = 0, comp3 = 0, last_hs3 = -10, stall_at = -1, stall_left = 0, stall_seen = 0;

  initial begin
    out_ready3 = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (stall_left > 0 && win_valid3 && hs3 == stall_at) begin
        out_ready3 = 1'b0;
        stall_left--;
      end else begin
        out_ready3 = 1'b1;
      end
    end
  end

  // ------------------------------------------------------ WIN=3 monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Reset_n) begin
        if (win_valid3 && !out_ready3) begin
          stall_seen++;
          check("stall_in_ready", in_ready3, 0);
          if (stall_at == 2) check("stall_win_stable", win3, THIRD3);
        end
        if (win_valid3 && out_ready3) begin
          if (sb3.size() == 0) begin
            check("unexpected_window3", 1, 0);
          end else begin
            e = sb3.pop_front();
            check("win3", win3, e.win);
            check("row3", row3, e.row);
            check("col3", col3, e.col);
          end
          if (hs3 == 0) begin
            check("first_win3", win3, FIRST3);
            check("first_row3", row3, 1);
            check("first_col3", col3, 1);
          end
          hs3++;
          if (hs3 == 12) check("last_win3_br", win3[71:64], 31);
          last_hs3 = cyc;
        end
        if (complete3) begin
          comp3++;
          check("complete_busy3", busy3, 0);
          check("complete_timing3", cyc, last_hs3 + 1);
        end
      end
    end
  end

  task automatic send_pixel3(input int v, input bit st);
    bit acc;
    acc = 0;
    in_valid3 = 1'b1;
    in_pix3   = 8'(v);
    start3    = st;
    for (int k = 0; k < 200 && !acc; k++) begin
      #1;
      if (in_ready3) begin
        acc = 1;
        if (v / 8 >= 2 && v % 8 >= 2)
          sb3.push_back('{win: mk_win(v / 8, v % 8, 3, 8), row: v / 8 - 1, col: v % 8 - 1});
      end
      @(posedge CLK);
      #1;
      start3 = 1'b0;
    end
    if (!acc) check("pixel_accept_timeout", 0, 1);
  endtask

  task automatic run_frame3(input int st_at, input bit start_mid, input bit idle_valid, input int reset_after);
    hs3 = 0; comp3 = 0; stall_seen = 0; sb3.delete();
    stall_at = st_at; stall_left = (st_at >= 0) ? 5 : 0;
    if (idle_valid) begin
      in_valid3 = 1'b1;
      in_pix3   = 8'hAA;
      for (int k = 0; k < 3; k++) begin
        @(posedge CLK);
        #2;
        check("idle_in_ready", in_ready3, 0);
        check("idle_busy", busy3, 0);
        #1;
      end
      in_valid3 = 1'b0;
    end
    @(posedge CLK); #1; start3 = 1'b1;
    @(posedge CLK); #1; start3 = 1'b0;
    check("busy_after_start", busy3, 1);
`ifdef SWIN_STATS_EN
    check("stall_cnt_cleared", stall_cnt3, 0);
`endif
    for (int p = 0; p < 32; p++) begin
      if (p == reset_after) begin
        in_valid3 = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("rst_win_valid", win_valid3, 0);
        check("rst_in_ready", in_ready3, 0);
        check("rst_busy", busy3, 0);
        check("rst_complete", complete3, 0);
        check("rst_win", win3, 0);
        check("rst_row", row3, 0);
        check("rst_col", col3, 0);
        sb3.delete();
        hs3 = 0;
        @(posedge CLK); #1;
        Reset_n = 1'b1;
        return;
      end
      send_pixel3(p, start_mid && p == 10);
    end
    in_valid3 = 1'b0;
    for (int k = 0; k < 100 && comp3 == 0; k++) @(posedge CLK);
    repeat (4) @(posedge CLK);
    #1;
    check("window_count3", hs3, 12);
    check("complete_count3", comp3, 1);
    check("scoreboard_empty3", sb3.size(), 0);
    if (st_at >= 0) check("stall_cycles", stall_seen, 5);
`ifdef SWIN_STATS_EN
    check("stall_cnt_frame", stall_cnt3, (st_at >= 0) ? 5 : 0);
`endif
  endtask

  // ---------------------------------------------------- WIN=5 stimulus/monitor
  int  hs5 = 0, comp5 = 0;
  bit  done5 = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (rst5_n && win_valid5 && out_ready5) begin
        if (sb5.size() == 0) begin
          check("unexpected_window5", 1, 0);
        end else begin
          e = sb5.pop_front();
          check("win5", win5, e.win);
          check("row5", row5, e.row);
          check("col5", col5, e.col);
        end
        if (hs5 == 0) begin
          check("first_win5_tl", win5[7:0], 0);
          check("first_win5_br", win5[199:192], 36);
          check("first_centre5", {row5, col5}, {3'd2, 3'd2});
        end
        hs5++;
        if (hs5 == 8) check("last_centre5", {row5, col5}, {3'd3, 3'd5});
      end
      if (rst5_n && complete5) comp5++;
    end
  end

  initial begin
    bit acc;
    rst5_n = 1'b0; start5 = 1'b0; in_valid5 = 1'b0; in_pix5 = '0; out_ready5 = 1'b1;
    repeat (3) @(posedge CLK);
    #1 rst5_n = 1'b1;
    @(posedge CLK); #1; start5 = 1'b1;
    @(posedge CLK); #1; start5 = 1'b0;
    for (int p = 0; p < 48; p++) begin
      in_valid5 = 1'b1;
      in_pix5   = 8'(p);
      acc = 0;
      for (int k = 0; k < 200 && !acc; k++) begin
        #1;
        if (in_ready5) begin
          acc = 1;
          if (p / 8 >= 4 && p % 8 >= 4)
            sb5.push_back('{win: mk_win(p / 8, p % 8, 5, 8), row: p / 8 - 2, col: p % 8 - 2});
        end
        @(posedge CLK);
        #1;
      end
      if (!acc) check("pixel_accept_timeout5", 0, 1);
    end
    in_valid5 = 1'b0;
    for (int k = 0; k < 100 && comp5 == 0; k++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    check("window_count5", hs5, 8);
    check("complete_count5", comp5, 1);
    done5 = 1;
  end

  // ------------------------------------------------------------- main
  initial begin
    Reset_n = 1'b0; start3 = 1'b0; in_valid3 = 1'b0; in_pix3 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_win_valid", win_valid3, 0);
    check("reset_in_ready", in_ready3, 0);
    check("reset_busy", busy3, 0);
    check("reset_complete", complete3, 0);
    check("reset_win", win3, 0);
    check("reset_coords", {row3, col3}, 0);
    Reset_n = 1'b1;

    run_frame3(-1, 0, 0, -1);  // plain streaming frame
    run_frame3(2, 0, 0, -1);   // 5-cycle backpressure at the 3rd window
    run_frame3(-1, 0, 0, 20);  // reset after 20 accepted pixels
    run_frame3(-1, 0, 0, -1);  // clean frame after reset
    run_frame3(-1, 1, 1, -1);  // Start during RUN, In_Valid in IDLE

    for (int k = 0; k < 2000 && !done5; k++) @(posedge CLK);
    check("win5_done", done5, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
